// File: rtl/video_pkg.sv
// Shared video constants: 1080p60 CEA-861 timing and RGB888 pixel format.
package video_pkg;

   localparam int H_ACT_1080  = 1920;
   localparam int H_FP_1080   = 88;
   localparam int H_SYNC_1080 = 44;
   localparam int H_BP_1080   = 148;
   localparam int V_ACT_1080  = 1080;
   localparam int V_FP_1080   = 4;
   localparam int V_SYNC_1080 = 5;
   localparam int V_BP_1080   = 36;
   localparam int CNT_W_DEF   = 12;

   localparam int PIX_W = 24;

   typedef logic [PIX_W-1:0] rgb_t;

   localparam rgb_t BLACK = 24'h0;

endpackage

// File: rtl/video_tcnt.sv
// Raster h/v counters with active and sync region decodes.
// Next-state counts are exported so callers can pre-register decodes.
module video_tcnt
   import video_pkg::*;
#(
   parameter int H_ACT  = H_ACT_1080,
   parameter int H_FP   = H_FP_1080,
   parameter int H_SYNC = H_SYNC_1080,
   parameter int H_BP   = H_BP_1080,
   parameter int V_ACT  = V_ACT_1080,
   parameter int V_FP   = V_FP_1080,
   parameter int V_SYNC = V_SYNC_1080,
   parameter int V_BP   = V_BP_1080,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic [CNT_W-1:0] h_nxt_o,
   output logic [CNT_W-1:0] v_nxt_o,
   output logic             act_o,
   output logic             hs_o,
   output logic             vs_o,
   output logic             org_o
);

   localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_AE   = CNT_W'(H_ACT);
   localparam logic [CNT_W-1:0] V_AE   = CNT_W'(V_ACT);
   localparam logic [CNT_W-1:0] HS_B   = CNT_W'(H_ACT + H_FP);
   localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_ACT + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_B   = CNT_W'(V_ACT + V_FP);
   localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_ACT + V_FP + V_SYNC);

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;

   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
      if (rst_i) begin
         h_d = '0;
         v_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      h_q <= h_d;
      v_q <= v_d;
   end

   assign h_nxt_o = h_d;
   assign v_nxt_o = v_d;
   assign act_o   = (h_q < H_AE) && (v_q < V_AE);
   assign hs_o    = (h_q >= HS_B) && (h_q < HS_E);
   assign vs_o    = (v_q >= VS_B) && (v_q < VS_E);
   assign org_o   = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/hdmi_out_tgen.sv
// HDMI transmit timing generator: windowed FWFT pixel pull, border fill,
// underrun substitution and accounting, start-of-frame pulse.
module hdmi_out_tgen
   import video_pkg::*;
#(
   parameter int H_ACT  = H_ACT_1080,
   parameter int H_FP   = H_FP_1080,
   parameter int H_SYNC = H_SYNC_1080,
   parameter int H_BP   = H_BP_1080,
   parameter int V_ACT  = V_ACT_1080,
   parameter int V_FP   = V_FP_1080,
   parameter int V_SYNC = V_SYNC_1080,
   parameter int V_BP   = V_BP_1080,
   parameter int HS_POL = 1,
   parameter int VS_POL = 1,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [CNT_W-1:0] win_x_i,
   input  logic [CNT_W-1:0] win_y_i,
   input  logic [CNT_W-1:0] win_w_i,
   input  logic [CNT_W-1:0] win_h_i,
   input  logic [23:0]      border_i,
   input  logic             pix_valid_i,
   input  logic [23:0]      pix_data_i,
   output logic             pix_rd_o,
   output logic             sof_o,
   output logic             vs_out,
   output logic             hs_out,
   output logic             de_out,
   output logic [23:0]      data_out,
   output logic [15:0]      underrun_cnt_o,
   output logic             underrun_flag_o
);

   localparam int CW1 = CNT_W + 1;

   localparam logic [CNT_W:0] X_LIM = CW1'(H_ACT);
   localparam logic [CNT_W:0] Y_LIM = CW1'(V_ACT);
   localparam logic           HSP   = (HS_POL != 0);
   localparam logic           VSP   = (VS_POL != 0);

   function automatic logic [CNT_W:0] clip_end(
      input logic [CNT_W-1:0] s,
      input logic [CNT_W-1:0] l,
      input logic [CNT_W:0]   lim
   );
      logic [CNT_W:0] e;
      e = {1'b0, s} + {1'b0, l};
      return (e > lim) ? lim : e;
   endfunction

   logic [CNT_W-1:0] h_nxt, v_nxt;
   logic             act, hs, vs, org;

   video_tcnt #(
      .H_ACT  (H_ACT),
      .H_FP   (H_FP),
      .H_SYNC (H_SYNC),
      .H_BP   (H_BP),
      .V_ACT  (V_ACT),
      .V_FP   (V_FP),
      .V_SYNC (V_SYNC),
      .V_BP   (V_BP),
      .CNT_W  (CNT_W)
   ) u_tcnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .h_nxt_o (h_nxt),
      .v_nxt_o (v_nxt),
      .act_o   (act),
      .hs_o    (hs),
      .vs_o    (vs),
      .org_o   (org)
   );

   logic [CNT_W-1:0] wx_q, wx_d, wy_q, wy_d;
   logic [CNT_W:0]   xe_q, xe_d, ye_q, ye_d;
   logic             load;
   logic             in_win_q, in_win_d;

   // Window reloads on the edge that enters (0,0), so it is stable all frame
   assign load = (h_nxt == '0) && (v_nxt == '0);

   always_comb begin
      wx_d = wx_q;
      wy_d = wy_q;
      xe_d = xe_q;
      ye_d = ye_q;
      if (load) begin
         wx_d = win_x_i;
         wy_d = win_y_i;
         xe_d = clip_end(win_x_i, win_w_i, X_LIM);
         ye_d = clip_end(win_y_i, win_h_i, Y_LIM);
      end
      in_win_d = ({1'b0, h_nxt} >= {1'b0, wx_d}) &&
                 ({1'b0, h_nxt} <  xe_d) &&
                 ({1'b0, v_nxt} >= {1'b0, wy_d}) &&
                 ({1'b0, v_nxt} <  ye_d);
   end

   assign pix_rd_o = in_win_q & ~rst_i;

   logic  ur;
   rgb_t  data_d;

   assign ur = pix_rd_o & ~pix_valid_i;

   always_comb begin
      data_d = BLACK;
      if (pix_rd_o) begin
         data_d = pix_valid_i ? pix_data_i : BLACK;
      end else if (act) begin
         data_d = border_i;
      end
   end

   logic [15:0] fcnt_q;
   logic [15:0] ucnt_q;
   logic        flag_q;
   logic        de_q, hs_q, vs_q, sof_q;
   rgb_t        data_q;

   always_ff @(posedge clk_i) begin
      wx_q     <= wx_d;
      wy_q     <= wy_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      in_win_q <= in_win_d;
      if (rst_i) begin
         de_q   <= 1'b0;
         hs_q   <= ~HSP;
         vs_q   <= ~VSP;
         sof_q  <= 1'b0;
         data_q <= BLACK;
         fcnt_q <= '0;
         ucnt_q <= '0;
         flag_q <= 1'b0;
      end else begin
         de_q   <= act;
         hs_q   <= hs ~^ HSP;
         vs_q   <= vs ~^ VSP;
         sof_q  <= org;
         data_q <= data_d;
         if (org) begin
            ucnt_q <= fcnt_q;
            fcnt_q <= {15'd0, ur};
         end else if (ur && (fcnt_q != 16'hFFFF)) begin
            fcnt_q <= fcnt_q + 16'd1;
         end
         if (ur) begin
            flag_q <= 1'b1;
         end
      end
   end

   assign de_out          = de_q;
   assign hs_out          = hs_q;
   assign vs_out          = vs_q;
   assign sof_o           = sof_q;
   assign data_out        = data_q;
   assign underrun_cnt_o  = ucnt_q;
   assign underrun_flag_o = flag_q;

endmodule
